// File: rtl/hidden_layer_serializer_pkg.sv
// rtl/hidden_layer_serializer_pkg.sv - shared widths, state encoding and defaults for the hidden-layer serializer
`ifndef dataWidth
`define dataWidth 16
`endif
`ifndef ROM_bitwidth
`define ROM_bitwidth 8
`endif

package hidden_layer_serializer_pkg;

   localparam logic HLS_COLLECT = 1'b0;
   localparam logic HLS_STREAM  = 1'b1;

   localparam int HLS_DEFAULT_NEURONS = 64;

   typedef enum logic {
      ST_COLLECT = HLS_COLLECT,
      ST_STREAM  = HLS_STREAM
   } hls_state_e;

endpackage

// File: rtl/hidden_layer_serializer_width_adapt.sv
// rtl/hidden_layer_serializer_width_adapt.sv - unsigned width adapter; HLS_SAT_EN selects saturation over truncation
module hls_width_adapt #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 16
) (
   input  logic [IN_WIDTH-1:0]  din,
   output logic [OUT_WIDTH-1:0] dout
);

   generate
      if (IN_WIDTH <= OUT_WIDTH) begin : g_extend
         assign dout = OUT_WIDTH'(din);
      end else begin : g_narrow
`ifdef HLS_SAT_EN
         assign dout = (|din[IN_WIDTH-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}} : din[OUT_WIDTH-1:0];
`else
         // Upper bits are intentionally dropped when truncating.
         logic unused_high;
         assign unused_high = ^din[IN_WIDTH-1:OUT_WIDTH];
         assign dout        = din[OUT_WIDTH-1:0];
`endif
      end
   endgenerate

endmodule

// File: rtl/hidden_layer_serializer.sv
// rtl/hidden_layer_serializer.sv - collects one hidden layer's neuron outputs and streams them in index order
// Narrowing behaviour when IN_WIDTH > OUT_WIDTH is selected by HLS_SAT_EN.
`ifndef dataWidth
`define dataWidth 16
`endif
`ifndef ROM_bitwidth
`define ROM_bitwidth 8
`endif

module hidden_layer_serializer
   import hidden_layer_serializer_pkg::*;
#(
   parameter int NUM_NEURONS = HLS_DEFAULT_NEURONS,
   parameter int IN_WIDTH    = `ROM_bitwidth,
   parameter int OUT_WIDTH   = `dataWidth
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_NEURONS-1:0]          in_valid,
   input  logic [NUM_NEURONS*IN_WIDTH-1:0] in_data,
   output logic [OUT_WIDTH-1:0]            out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_last,
   output logic                            layer_done,
   output logic                            overrun,
   input  logic                            clear_overrun
);

   localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   hls_state_e state, state_next;

   logic [IN_WIDTH-1:0]    buf_q    [NUM_NEURONS];
   logic [IN_WIDTH-1:0]    buf_next [NUM_NEURONS];
   logic [NUM_NEURONS-1:0] mask, mask_next;
   logic [IDX_W-1:0]       idx, idx_next, idx_inc;

   logic                   handshake, last_hs, mask_full, overrun_event;
   logic                   load_word;
   logic                   out_valid_next, out_last_next;
   logic [IN_WIDTH-1:0]    word_sel;
   logic [OUT_WIDTH-1:0]   word_adapt, out_data_next;

   assign handshake     = out_valid & out_ready;
   assign last_hs       = handshake & (idx == LAST_IDX);
   assign mask_full     = &mask;
   assign overrun_event = (state == ST_STREAM) & (|in_valid);
   assign idx_inc       = idx + 1'b1;

   // Captures that land on the transition edge are forwarded so word 0 sees them.
   always_comb begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
         buf_next[i] = buf_q[i];
         if (state == ST_COLLECT && in_valid[i]) begin
            buf_next[i] = in_data[i*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   always_comb begin
      state_next     = state;
      mask_next      = mask;
      idx_next       = idx;
      out_valid_next = out_valid;
      out_last_next  = out_last;
      load_word      = 1'b0;
      word_sel       = buf_next[0];
      case (state)
         ST_COLLECT: begin
            mask_next = mask | in_valid;
            if (mask_full) begin
               state_next     = ST_STREAM;
               idx_next       = '0;
               out_valid_next = 1'b1;
               out_last_next  = 1'b0;
               load_word      = 1'b1;
               word_sel       = buf_next[0];
            end
         end
         ST_STREAM: begin
            if (handshake) begin
               if (idx == LAST_IDX) begin
                  state_next     = ST_COLLECT;
                  mask_next      = '0;
                  idx_next       = '0;
                  out_valid_next = 1'b0;
                  out_last_next  = 1'b0;
               end else begin
                  idx_next      = idx_inc;
                  out_last_next = (idx_inc == LAST_IDX);
                  load_word     = 1'b1;
                  word_sel      = buf_q[idx_inc];
               end
            end
         end
         default: state_next = ST_COLLECT;
      endcase
   end

   hls_width_adapt #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_adapt (
      .din  (word_sel),
      .dout (word_adapt)
   );

   always_comb begin
      out_data_next = out_data;
      if (load_word) begin
         out_data_next = word_adapt;
      end else if (last_hs) begin
         out_data_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_COLLECT;
         mask       <= '0;
         idx        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         layer_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         mask       <= mask_next;
         idx        <= idx_next;
         out_valid  <= out_valid_next;
         out_data   <= out_data_next;
         out_last   <= out_last_next;
         layer_done <= last_hs;
         // A new event wins over a same-cycle clear.
         overrun    <= overrun_event | (overrun & ~clear_overrun);
      end
   end

   // Stale buffer contents are harmless: the mask gates every use.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
         buf_q[i] <= buf_next[i];
      end
   end

endmodule

// File: tb/tb_hidden_layer_serializer.sv
// tb/tb_hidden_layer_serializer.sv - randomized self-checking bench with a behavioural layer model
`timescale 1ns/1ps
module tb_hidden_layer_serializer;

   localparam int N  = 4;
   localparam int IW = 12;
   localparam int OW = 8;
`ifdef HLS_SAT_EN
   localparam logic [OW-1:0] ADAPT_1A5 = 8'hFF;
`else
   localparam logic [OW-1:0] ADAPT_1A5 = 8'hA5;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    in_valid = '0;
   logic [N*IW-1:0] in_data = '0;
   logic            out_ready = 1'b1;
   logic            clear_overrun = 1'b0;
   logic [OW-1:0]   out_data;
   logic            out_valid, out_last, layer_done, overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hidden_layer_serializer #(
      .NUM_NEURONS (N),
      .IN_WIDTH    (IW),
      .OUT_WIDTH   (OW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .layer_done    (layer_done),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   function automatic logic [OW-1:0] ref_adapt(input logic [IW-1:0] v);
      longint x;
      longint lim;
      x   = longint'(v);
      lim = longint'(1) << OW;
      if (IW <= OW) return OW'(x);
`ifdef HLS_SAT_EN
      if (x >= lim) return {OW{1'b1}};
`endif
      return OW'(x % lim);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural model: which neurons have reported, whether a layer is being played out and where.
   logic [IW-1:0] m_buf [N];
   logic [N-1:0]  m_got;
   bit            m_stream, m_done, m_ovr, m_full;
   int            m_pos;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_got = '0; m_stream = 0; m_pos = 0; m_done = 0; m_ovr = 0;
      end else begin
         m_done = 0;
         if (m_stream) begin
            m_ovr = (in_valid != '0) ? 1'b1 : (clear_overrun ? 1'b0 : m_ovr);
            if (out_ready) begin
               if (m_pos == N - 1) begin
                  m_stream = 0; m_pos = 0; m_got = '0; m_done = 1;
               end else begin
                  m_pos = m_pos + 1;
               end
            end
         end else begin
            if (clear_overrun) m_ovr = 0;
            m_full = (m_got == {N{1'b1}});
            for (int i = 0; i < N; i++) begin
               if (in_valid[i]) begin
                  m_buf[i] = in_data[i*IW +: IW];
                  m_got[i] = 1'b1;
               end
            end
            if (m_full) begin
               m_stream = 1; m_pos = 0;
            end
         end
      end
   end

   logic [OW-1:0] got_words[$];
   int            hs_count = 0;
   int            done_count = 0;

   always @(negedge clk) begin
      check("out_valid", out_valid, m_stream);
      check("out_last", out_last, (m_stream && m_pos == N - 1));
      check("layer_done", layer_done, m_done);
      check("overrun", overrun, m_ovr);
      if (m_stream) check("out_data", out_data, ref_adapt(m_buf[m_pos]));
      if (out_valid && out_ready) begin
         got_words.push_back(out_data);
         hs_count++;
      end
      if (layer_done) done_count++;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int i, input logic [IW-1:0] v);
      in_data[i*IW +: IW] = v;
   endtask

   task automatic pulse_all();
      in_valid = '1;
      tick();
      in_valid = '0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         tick();
         if (layer_done) seen = 1;
      end
      check(name, seen, 1'b1);
   endtask

   task automatic wait_valid(input string name, input int budget);
      bit seen;
      seen = out_valid;
      for (int c = 0; c < budget && !seen; c++) begin
         tick();
         if (out_valid) seen = 1;
      end
      check(name, seen, 1'b1);
   endtask

   initial begin
      int hs0;
      bit [3:0] pat;

      // Reset state.
      tick(2);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_layer_done", layer_done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      tick();

      // All four neurons together, ready held high.
      got_words.delete();
      set_word(0, 12'h010); set_word(1, 12'h020); set_word(2, 12'h030); set_word(3, 12'h040);
      pulse_all();
      check("lat_early_valid", out_valid, 1'b0);
      tick();
      check("lat_valid", out_valid, 1'b1);
      check("lat_word0", out_data, 8'h10);
      wait_done("t1_done", 20);
      check("t1_count", got_words.size(), 4);
      check("t1_w0", got_words[0], 8'h10);
      check("t1_w1", got_words[1], 8'h20);
      check("t1_w2", got_words[2], 8'h30);
      check("t1_w3", got_words[3], 8'h40);
      tick();
      check("t1_done_width", layer_done, 1'b0);

      // Skewed valids with a repeated neuron 2.
      got_words.delete();
      for (int c = 0; c < 8; c++) begin
         in_valid = '0;
         case (c)
            0: begin set_word(2, 12'h055); in_valid = 4'b0100; end
            3: begin set_word(0, 12'h001); set_word(1, 12'h002); in_valid = 4'b0011; end
            5: begin set_word(2, 12'h099); in_valid = 4'b0100; end
            7: begin set_word(3, 12'h004); in_valid = 4'b1000; end
            default: ;
         endcase
         tick();
      end
      in_valid = '0;
      check("skew_not_yet", out_valid, 1'b0);
      tick();
      check("skew_start", out_valid, 1'b1);
      wait_done("skew_done", 20);
      check("skew_w2", got_words[2], 8'h99);
      check("skew_overrun", overrun, 1'b0);

      // Ready pattern 1,0,0,1 during the stream.
      hs0 = hs_count;
      pat = 4'b1001;
      for (int i = 0; i < N; i++) set_word(i, IW'($urandom_range(0, 255)));
      for (int c = 0; c < 24; c++) begin
         in_valid  = (c == 0) ? '1 : '0;
         out_ready = pat[c % 4];
         tick();
      end
      out_ready = 1'b1;
      check("toggle_handshakes", hs_count - hs0, 4);

      // Overrun set, cleared, and set-wins on a same-cycle clear.
      pulse_all();
      wait_valid("ovr_valid", 10);
      in_valid = 4'b0010;
      tick();
      in_valid = '0;
      check("ovr_set", overrun, 1'b1);
      wait_done("ovr_done", 20);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      check("ovr_clear", overrun, 1'b0);
      pulse_all();
      wait_valid("ovr2_valid", 10);
      in_valid = 4'b1000;
      clear_overrun = 1'b1;
      tick();
      in_valid = '0;
      clear_overrun = 1'b0;
      check("ovr_set_wins", overrun, 1'b1);
      wait_done("ovr2_done", 20);

      // Narrowing of an out-of-range word.
      set_word(0, 12'h1A5);
      pulse_all();
      tick();
      check("adapt_1a5", out_data, ADAPT_1A5);
      wait_done("adapt_done", 20);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) set_word(i, IW'($urandom_range(0, 4095)));
         in_valid      = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         out_ready     = ($urandom_range(0, 3) != 0);
         clear_overrun = ($urandom_range(0, 9) == 0);
         tick();
      end
      in_valid = '0;
      clear_overrun = 1'b1;
      out_ready = 1'b1;
      tick(12);
      clear_overrun = 1'b0;
      check("random_layers_seen", (done_count > 5), 1'b1);

      // Reset in the middle of a stream.
      for (int i = 0; i < N; i++) set_word(i, 12'h011 * (i + 1));
      in_valid = '1;
      tick();
      in_valid = '0;
      wait_valid("mid_valid", 10);
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_last", out_last, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      got_words.delete();
      set_word(0, 12'h0A1); set_word(1, 12'h0B2); set_word(2, 12'h0C3); set_word(3, 12'h0D4);
      pulse_all();
      tick();
      check("post_rst_w0", out_data, 8'hA1);
      wait_done("post_rst_done", 20);
      check("post_rst_count", got_words.size(), 4);
      check("post_rst_w3", got_words[3], 8'hD4);

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
